// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter: operation codes and the
// mapping of mux levels onto pipeline stages.
package shift_pkg;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;

    // Stage that owns mux level 'level' when SHW levels are spread over PIPE stages.
    function automatic int level_stage(input int level, input int shw, input int pipe);
        return (level * pipe) / shw;
    endfunction

    function automatic bit stage_first(input int level, input int shw, input int pipe);
        return (level == 0) || (level_stage(level - 1, shw, pipe) != level_stage(level, shw, pipe));
    endfunction

    function automatic bit stage_last(input int level, input int shw, input int pipe);
        return (level == shw - 1) || (level_stage(level + 1, shw, pipe) != level_stage(level, shw, pipe));
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the shift network: moves the operand by DIST
// positions when enabled, with the fill selected by the operation mode.
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        // NOTE: result gets a default before the case so every path assigns it and no latch is inferred.
        result = data;
        if (enable) begin
            case (mode)
                MODE_SLL: result = data << DIST;
                MODE_SRL: result = data >> DIST;
                MODE_SRA: result = {{DIST{data[WIDTH-1]}}, data[WIDTH-1:DIST]};
                MODE_ROL: result = {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
                MODE_ROR: result = {data[DIST-1:0], data[WIDTH-1:DIST]};
                default:  result = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready handshake, global stall
// and a pass-through tag; latency is PIPE cycles when not stalled.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amount,
    input  logic [2:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SHW = $clog2(WIDTH);

    logic advance;

    logic [WIDTH-1:0] rank_data   [PIPE];
    logic [SHW-1:0]   rank_amount [PIPE];
    logic [2:0]       rank_mode   [PIPE];
    logic [TAG_W-1:0] rank_tag    [PIPE];
    logic             rank_valid  [PIPE];

    logic [WIDTH-1:0] stage_data   [PIPE];
    logic [SHW-1:0]   stage_amount [PIPE];
    logic [2:0]       stage_mode   [PIPE];
    logic [TAG_W-1:0] stage_tag    [PIPE];
    logic             stage_valid  [PIPE];
    logic [WIDTH-1:0] stage_result [PIPE];

    logic [WIDTH-1:0] level_in  [SHW];
    logic [WIDTH-1:0] level_out [SHW];

    // Single global stall: the whole pipe freezes, bubbles included.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = rank_valid[PIPE-1];
    assign out_data  = rank_data[PIPE-1];
    assign out_tag   = rank_tag[PIPE-1];

    for (genvar s = 0; s < PIPE; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign stage_data[s]   = in_data;
            assign stage_amount[s] = in_amount;
            assign stage_mode[s]   = in_mode;
            assign stage_tag[s]    = in_tag;
            assign stage_valid[s]  = in_valid;
        end else begin : g_body
            assign stage_data[s]   = rank_data[s-1];
            assign stage_amount[s] = rank_amount[s-1];
            assign stage_mode[s]   = rank_mode[s-1];
            assign stage_tag[s]    = rank_tag[s-1];
            assign stage_valid[s]  = rank_valid[s-1];
        end
    end

    for (genvar i = 0; i < SHW; i++) begin : g_level
        localparam int STG = level_stage(i, SHW, PIPE);

        if (stage_first(i, SHW, PIPE)) begin : g_first
            assign level_in[i] = stage_data[STG];
        end else begin : g_chain
            assign level_in[i] = level_out[i-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << i)
        ) u_level (
            .data   (level_in[i]),
            .enable (stage_amount[STG][i]),
            .mode   (stage_mode[STG]),
            .result (level_out[i])
        );

        if (stage_last(i, SHW, PIPE)) begin : g_last
            assign stage_result[STG] = level_out[i];
        end
    end

    // NOTE: every rank field is cleared on reset, not just valid, so out_data/out_tag read 0 afterwards.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int s = 0; s < PIPE; s++) begin
                rank_valid[s]  <= 1'b0;
                rank_data[s]   <= '0;
                rank_amount[s] <= '0;
                rank_mode[s]   <= '0;
                rank_tag[s]    <= '0;
            end
        end else if (advance) begin
            // NOTE: non-blocking updates let every rank sample its predecessor's old value in the same edge.
            for (int s = 0; s < PIPE; s++) begin
                rank_valid[s]  <= stage_valid[s];
                rank_data[s]   <= stage_result[s];
                rank_amount[s] <= stage_amount[s];
                rank_mode[s]   <= stage_mode[s];
                rank_tag[s]    <= stage_tag[s];
            end
        end
    end

endmodule
